seq_stream_parser: RTL

- Parametrised successor to the single-buffer stream parser. Receives length-prefixed, sequence-numbered packets on a 32-bit valid/ready stream and emits one wide, byte-packed payload per packet.
- Tracks a sequence number for each of NUM_STREAMS streams and reports lost packets together with the gap size.
- Flags malformed packets instead of corrupting state.
- Double-buffered: the next packet is received while the previous one waits on the output.

---
 rtl/seq_stream_parser.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_stream_parser.sv
// seq_stream_parser: receives length-prefixed, sequence-numbered packets on a
// 32-bit stream, packs each payload into one wide word, tracks a per-slot
// sequence number and flags lost or malformed packets.
//
// Handshake: a word moves on dataIn when dataIn_val && dataIn_ready; a packet
// moves on dataOut when dataOut_val && dataOut_ready. A valid output holds all
// its fields stable until it is consumed.
module seq_stream_parser #(
    parameter int NUM_STREAMS       = 32,
    parameter int MAX_PAYLOAD_BYTES = 37,
    parameter int BCNT_W            = 16,
    localparam int OUT_W            = 8 * MAX_PAYLOAD_BYTES
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [31:0]       dataIn,
    input  logic              dataIn_val,
    output logic              dataIn_ready,
    input  logic              dataIn_last,
    output logic [OUT_W-1:0]  dataOut,
    output logic              dataOut_val,
    input  logic              dataOut_ready,
    output logic [BCNT_W-1:0] dataOut_bytes,
    output logic [15:0]       dataOut_stream,
    output logic [31:0]       dataOut_seq,
    output logic              dataOut_err,
    output logic              packetLost,
    output logic [31:0]       lostCount,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(NUM_STREAMS);

    typedef enum logic [1:0] {S_IDLE, S_HDR2, S_DATA, S_FULL} state_t;

    // Receive side (prepare buffer)
    state_t            state_q, state_d;
    logic [OUT_W-1:0]  pbuf_q, pbuf_d;
    logic [BCNT_W-1:0] pbytes_q, pbytes_d;
    logic [15:0]       pstream_q, pstream_d;
    logic [15:0]       rem_q, rem_d;      // payload bytes still expected per the header
    logic [31:0]       pseq_q, pseq_d;
    logic              perr_q, perr_d;

    // Output register
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_val_q, out_val_d;
    logic [BCNT_W-1:0] out_bytes_q, out_bytes_d;
    logic [15:0]       out_stream_q, out_stream_d;
    logic [31:0]       out_seq_q, out_seq_d;
    logic              out_err_q, out_err_d;
    logic              lost_q, lost_d;
    logic [31:0]       lost_cnt_q, lost_cnt_d;

    // Last sequence number seen per slot
    logic [31:0]       seq_tab_q [NUM_STREAMS];
    logic              tab_we;
    logic [IDX_W-1:0]  tab_idx;
    logic [31:0]       tab_expected;

    logic              accept;
    logic              done;
    logic              complete;
    logic              out_free;
    logic [2:0]        nvalid;
    logic [BCNT_W-1:0] nstored;
    logic [15:0]       len_w;

    assign accept = dataIn_val && (state_q != S_FULL);
    assign len_w  = dataIn[31:16];
    assign nvalid = (rem_q >= 16'd4) ? 3'd4 : rem_q[2:0];

    // Next-state logic: packet parsing, byte packing, hand-off and sequence check
    always_comb begin
        state_d      = state_q;
        pbuf_d       = pbuf_q;
        pbytes_d     = pbytes_q;
        pstream_d    = pstream_q;
        rem_d        = rem_q;
        pseq_d       = pseq_q;
        perr_d       = perr_q;
        out_data_d   = out_data_q;
        out_val_d    = out_val_q && !dataOut_ready;
        out_bytes_d  = out_bytes_q;
        out_stream_d = out_stream_q;
        out_seq_d    = out_seq_q;
        out_err_d    = out_err_q;
        lost_d       = lost_q;
        lost_cnt_d   = lost_cnt_q;
        done         = 1'b0;
        nstored      = '0;
        tab_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pbuf_d    = '0;
                    pbytes_d  = '0;
                    pstream_d = dataIn[15:0];
                    pseq_d    = '0;
                    rem_d     = (len_w >= 16'd8) ? (len_w - 16'd8) : 16'd0;
                    // Header cut short, length too small, or payload beyond capacity
                    perr_d    = dataIn_last || (len_w < 16'd8) ||
                                (32'(len_w) > 32'(MAX_PAYLOAD_BYTES + 8));
                    if (dataIn_last) done = 1'b1;
                    else             state_d = S_HDR2;
                end
            end
            S_HDR2: begin
                if (accept) begin
                    pseq_d = dataIn;
                    if (rem_q == 16'd0) begin
                        // Header-only packet must end on the sequence word
                        if (dataIn_last) begin
                            done = 1'b1;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = S_DATA;
                        end
                    end else if (dataIn_last) begin
                        perr_d = 1'b1;
                        done   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // A word arriving after the announced payload is extra
                    if (rem_q == 16'd0) perr_d = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        if ((k < int'(nvalid)) &&
                            (int'(pbytes_q) + k < MAX_PAYLOAD_BYTES)) begin
                            pbuf_d[OUT_W - 8 - 8 * (int'(pbytes_q) + k) +: 8] =
                                dataIn[31 - 8 * k -: 8];
                            nstored = nstored + BCNT_W'(1);
                        end
                    end
                    pbytes_d = pbytes_q + nstored;
                    rem_d    = rem_q - 16'(nvalid);
                    if (dataIn_last) begin
                        if (rem_q > 16'd4) perr_d = 1'b1;
                        done = 1'b1;
                    end
                end
            end
            default: ; // S_FULL: hold the complete packet
        endcase

        complete = (state_q == S_FULL) || done;
        out_free = !out_val_q || dataOut_ready;

        tab_idx      = pstream_d[IDX_W-1:0];
        tab_expected = seq_tab_q[tab_idx] + 32'd1;

        if (complete) begin
            if (out_free) begin
                out_val_d    = 1'b1;
                out_data_d   = pbuf_d;
                out_bytes_d  = pbytes_d;
                out_stream_d = pstream_d;
                out_seq_d    = pseq_d;
                out_err_d    = perr_d;
                if (perr_d) begin
                    lost_d     = 1'b0;
                    lost_cnt_d = '0;
                end else begin
                    lost_d     = (pseq_d != tab_expected);
                    lost_cnt_d = pseq_d - tab_expected;
                    tab_we     = 1'b1;
                end
                state_d = S_IDLE;
            end else begin
                state_d = S_FULL;
            end
        end
    end

    // State, buffers and sequence table; reset discards any partial packet
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= S_IDLE;
            pbuf_q       <= '0;
            pbytes_q     <= '0;
            pstream_q    <= '0;
            rem_q        <= '0;
            pseq_q       <= '0;
            perr_q       <= 1'b0;
            out_data_q   <= '0;
            out_val_q    <= 1'b0;
            out_bytes_q  <= '0;
            out_stream_q <= '0;
            out_seq_q    <= '0;
            out_err_q    <= 1'b0;
            lost_q       <= 1'b0;
            lost_cnt_q   <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) seq_tab_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pbuf_q       <= pbuf_d;
            pbytes_q     <= pbytes_d;
            pstream_q    <= pstream_d;
            rem_q        <= rem_d;
            pseq_q       <= pseq_d;
            perr_q       <= perr_d;
            out_data_q   <= out_data_d;
            out_val_q    <= out_val_d;
            out_bytes_q  <= out_bytes_d;
            out_stream_q <= out_stream_d;
            out_seq_q    <= out_seq_d;
            out_err_q    <= out_err_d;
            lost_q       <= lost_d;
            lost_cnt_q   <= lost_cnt_d;
            if (tab_we) seq_tab_q[tab_idx] <= pseq_d;
        end
    end

    assign dataIn_ready   = (state_q != S_FULL);
    assign dataOut        = out_data_q;
    assign dataOut_val    = out_val_q;
    assign dataOut_bytes  = out_bytes_q;
    assign dataOut_stream = out_stream_q;
    assign dataOut_seq    = out_seq_q;
    assign dataOut_err    = out_err_q;
    assign packetLost     = lost_q;
    assign lostCount      = lost_cnt_q;
    assign dbg_state      = state_q;

endmodule
